audio_pwm_out: RTL and testbench

//  Converts the BITRES-bit pulsewidth stream from the waveform generators into
//  a 1-bit PWM pin that drives the external audio amplifier. It sits at the far end
//  of the pulsewidth interface, between the channel mixer and the board pin.
//  - Duty is updated only on frame boundaries, so the output never glitches mid-frame.
//  - A soft ramp of the idle level at power-up and power-down suppresses clicks.

---
 rtl/audio_pwm_out_pkg.sv | 12 +
 rtl/audio_pwm_frame_timer.sv | 35 +++
 rtl/audio_pwm_out.sv | 110 +++++++++++
 tb/tb_audio_pwm_out.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/audio_pwm_out_pkg.sv
// rtl/audio_pwm_out_pkg.sv - shared widths, idle level and FSM states for the audio PWM path
package audio_pwm_out_pkg;
    localparam int BITRES = 4;
    localparam logic [BITRES-1:0] PWM_MUTED = BITRES'(8);

    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_RAMP_UP = 2'd1,
        ST_RUN     = 2'd2,
        ST_RAMP_DN = 2'd3
    } pwm_state_e;
endpackage

// File: rtl/audio_pwm_frame_timer.sv
// rtl/audio_pwm_frame_timer.sv - free-running slot divider, slot counter and end-of-frame strobe
module audio_pwm_frame_timer
    import audio_pwm_out_pkg::*;
#(
    parameter int CLKDIV = 64
) (
    input  logic              clk,
    input  logic              resetn,
    output logic [BITRES-1:0] slot_cnt,
    output logic              frame_strobe
);
    localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam logic [DW-1:0]     DIV_LAST = DW'(CLKDIV - 1);
    localparam logic [DW-1:0]     DIV_PRE  = DW'(CLKDIV - 2);
    localparam logic [BITRES-1:0] SLOT_MAX = '1;

    logic [DW-1:0] div_cnt;

    // Strobe is decoded one clock early so the registered pulse lands in the frame's last clock.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_cnt      <= '0;
            slot_cnt     <= '0;
            frame_strobe <= 1'b0;
        end else begin
            frame_strobe <= (div_cnt == DIV_PRE) && (slot_cnt == SLOT_MAX);
            if (div_cnt == DIV_LAST) begin
                div_cnt  <= '0;
                slot_cnt <= slot_cnt + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/audio_pwm_out.sv
// rtl/audio_pwm_out.sv - frame-synchronous PWM audio output with click-free amp power ramps
module audio_pwm_out
    import audio_pwm_out_pkg::*;
#(
    parameter int CLKDIV      = 64,
    parameter int RAMP_FRAMES = 256
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              enable,
    input  logic              mute,
    input  logic [BITRES-1:0] pulsewidth,
    output logic              pwm_out,
    output logic              amp_sd_n,
    output logic              frame_strobe,
    output logic              running
);
    localparam int RW = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;
    localparam logic [RW-1:0] RC_LAST = RW'(RAMP_FRAMES - 1);

    pwm_state_e        state;
    logic [BITRES-1:0] slot_cnt;
    logic [BITRES-1:0] duty_q;
    logic [BITRES-1:0] ramp_lvl;
    logic [RW-1:0]     ramp_cnt;
    logic              ramp_tick;

    audio_pwm_frame_timer #(.CLKDIV(CLKDIV)) u_timer (
        .clk          (clk),
        .resetn       (resetn),
        .slot_cnt     (slot_cnt),
        .frame_strobe (frame_strobe)
    );

    assign ramp_tick = (ramp_cnt == RC_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_OFF;
            duty_q   <= '0;
            ramp_lvl <= '0;
            ramp_cnt <= '0;
            pwm_out  <= 1'b0;
            amp_sd_n <= 1'b0;
            running  <= 1'b0;
        end else begin
            pwm_out <= (slot_cnt < duty_q);
            if (frame_strobe) begin
                case (state)
                    ST_OFF: begin
                        duty_q <= '0;
                        if (enable) begin
                            state    <= ST_RAMP_UP;
                            amp_sd_n <= 1'b1;
                            ramp_lvl <= '0;
                            ramp_cnt <= '0;
                        end
                    end
                    ST_RAMP_UP: begin
                        duty_q <= ramp_lvl;
                        if (!enable) begin
                            state    <= ST_RAMP_DN;
                            ramp_cnt <= '0;
                        end else if (ramp_lvl == PWM_MUTED) begin
                            state    <= ST_RUN;
                            running  <= 1'b1;
                            ramp_cnt <= '0;
                        end else if (ramp_tick) begin
                            ramp_lvl <= ramp_lvl + 1'b1;
                            ramp_cnt <= '0;
                        end else begin
                            ramp_cnt <= ramp_cnt + 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (!enable) begin
                            // Cut any audio at this boundary and start the fade from the idle level.
                            duty_q   <= PWM_MUTED;
                            state    <= ST_RAMP_DN;
                            running  <= 1'b0;
                            ramp_lvl <= PWM_MUTED;
                            ramp_cnt <= '0;
                        end else begin
                            duty_q <= mute ? PWM_MUTED : pulsewidth;
                        end
                    end
                    ST_RAMP_DN: begin
                        duty_q <= ramp_lvl;
                        if (enable) begin
                            state    <= ST_RAMP_UP;
                            ramp_cnt <= '0;
                        end else if (ramp_lvl == '0) begin
                            state    <= ST_OFF;
                            amp_sd_n <= 1'b0;
                            ramp_cnt <= '0;
                        end else if (ramp_tick) begin
                            ramp_lvl <= ramp_lvl - 1'b1;
                            ramp_cnt <= '0;
                        end else begin
                            ramp_cnt <= ramp_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_OFF;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_audio_pwm_out.sv
// tb/tb_audio_pwm_out.sv - directed self-checking bench for audio_pwm_out (4 clk/slot, 2 frames/step)
module tb_audio_pwm_out;
    import audio_pwm_out_pkg::*;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              enable = 1'b0;
    logic              mute = 1'b0;
    logic [BITRES-1:0] pulsewidth = '0;
    logic              pwm_out;
    logic              amp_sd_n;
    logic              frame_strobe;
    logic              running;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    audio_pwm_out #(.CLKDIV(4), .RAMP_FRAMES(2)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .enable       (enable),
        .mute         (mute),
        .pulsewidth   (pulsewidth),
        .pwm_out      (pwm_out),
        .amp_sd_n     (amp_sd_n),
        .frame_strobe (frame_strobe),
        .running      (running)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic sync_strobe();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_strobe && n < 200);
        if (!frame_strobe) chk("sync_timeout", 0, 1);
    endtask

    // Observes one whole 64-clock frame; inputs may be changed at clock index 'at' (-1 = none).
    task automatic frame(input string tag, input int at, input logic [BITRES-1:0] pw,
                         input logic mu, input logic en,
                         input int exp_hi, input int exp_amp, input int exp_run);
        int hi = 0;
        int f_amp = 0;
        int f_run = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (i == 0) begin
                f_amp = int'(amp_sd_n);
                f_run = int'(running);
            end
            hi += int'(pwm_out);
            if (i == at) begin
                pulsewidth = pw;
                mute       = mu;
                enable     = en;
            end
        end
        chk({tag, "_hi"}, hi, exp_hi);
        chk({tag, "_amp"}, f_amp, exp_amp);
        chk({tag, "_run"}, f_run, exp_run);
        chk({tag, "_stb"}, int'(frame_strobe), 1);
    endtask

    task automatic check_ramp_up(input string nm);
        int lvl;
        for (int k = 0; k < 18; k++) begin
            lvl = (k < 3) ? 0 : ((k < 17) ? (k - 3) / 2 + 1 : 8);
            frame($sformatf("%s%0d", nm, k), -1, pulsewidth, mute, enable,
                  lvl * 4, 1, (k == 17) ? 1 : 0);
        end
    endtask

    task automatic count_strobes(input int n, output int first, output int cnt,
                                 output int pwm_any, output int amp_any);
        first = -1;
        cnt = 0;
        pwm_any = 0;
        amp_any = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (frame_strobe) begin
                if (first < 0) first = i;
                cnt++;
            end
            if (pwm_out) pwm_any = 1;
            if (amp_sd_n) amp_any = 1;
        end
    endtask

    initial begin
        int first, cnt, pwm_any, amp_any, lvl;
        int exp_part[16];
        exp_part = '{8, 8, 8, 7, 7, 6, 6, 5, 5, 5, 5, 6, 6, 7, 7, 8};

        repeat (3) @(negedge clk);
        chk("rst_pwm", int'(pwm_out), 0);
        chk("rst_amp", int'(amp_sd_n), 0);
        chk("rst_stb", int'(frame_strobe), 0);
        chk("rst_run", int'(running), 0);
        resetn = 1'b1;

        count_strobes(500, first, cnt, pwm_any, amp_any);
        chk("off_first_stb", first, 62);
        chk("off_stb_count", cnt, 7);
        chk("off_pwm", pwm_any, 0);
        chk("off_amp", amp_any, 0);

        pulsewidth = 4'd8;
        enable = 1'b1;
        sync_strobe();
        check_ramp_up("up");

        frame("pw3_set",  0,  4'd3,  1'b0, 1'b1, 32, 1, 1);
        frame("pw3",      20, 4'd15, 1'b0, 1'b1, 12, 1, 1);
        frame("pw15",     10, 4'd0,  1'b0, 1'b1, 60, 1, 1);
        frame("pw0",      5,  4'd13, 1'b1, 1'b1, 0,  1, 1);
        frame("muted",    30, 4'd13, 1'b0, 1'b1, 32, 1, 1);
        frame("pw13",     40, 4'd13, 1'b0, 1'b0, 52, 1, 1);

        for (int j = 0; j < 18; j++) begin
            lvl = (j < 3) ? 8 : ((j < 17) ? 8 - ((j - 3) / 2 + 1) : 0);
            frame($sformatf("dn%0d", j), (j == 17) ? 10 : -1, 4'd13, 1'b0,
                  (j == 17) ? 1'b1 : 1'b0, lvl * 4, (j < 17) ? 1 : 0, 0);
        end

        check_ramp_up("reup");
        frame("dis2", 5, 4'd13, 1'b0, 1'b0, 52, 1, 1);
        for (int j = 0; j < 16; j++) begin
            frame($sformatf("part%0d", j), (j == 7) ? 10 : -1, 4'd13, 1'b0, 1'b1,
                  exp_part[j] * 4, 1, (j == 15) ? 1 : 0);
        end

        repeat (10) @(negedge clk);
        chk("pre_rst_pwm", int'(pwm_out), 1);
        enable = 1'b0;
        #2 resetn = 1'b0;
        #1;
        chk("arst_pwm", int'(pwm_out), 0);
        chk("arst_amp", int'(amp_sd_n), 0);
        chk("arst_stb", int'(frame_strobe), 0);
        chk("arst_run", int'(running), 0);
        @(negedge clk);
        resetn = 1'b1;
        count_strobes(200, first, cnt, pwm_any, amp_any);
        chk("rel_first_stb", first, 62);
        chk("rel_stb_count", cnt, 3);
        chk("rel_pwm", pwm_any, 0);
        chk("rel_amp", amp_any, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
